control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Receiving end of the main decoder's control bundle in the 5-stage MIPS pipeline.
- Registers decoded control through the ID/EX, EX/MEM and MEM/WB boundaries.
- In EX, expands ALUOp plus funct into the 4-bit ALU select.
- Resolves beq/bne in EX and raises load-use stall and branch flush to the fetch/decode side.

Parameters:
- REG_AW, 5, register address width
- ALU_CW, 4, ALU select width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_opcode  in  6  opcode; used only to tell bne (000101) from beq
- id_funct  in  6  instr[5:0]
- id_ctrl  in  7  {RegDest,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite}, MSB first
- id_alu_op  in  3  decoder ALUOp
- id_rs, id_rt, id_rd  in  REG_AW  register fields
- ex_zero  in  1  ALU zero flag, combinational in EX
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  squash the IF/ID slot at next edge
- pc_src  out  1  take branch target this cycle
- ex_alu_ctrl  out  ALU_CW  ALU select for the EX instruction
- ex_alu_src  out  1  ALU B from immediate
- mem_read, mem_write  out  1  data-memory strobes, MEM stage
- wb_reg_write  out  1  register-file write enable, WB stage
- wb_mem_to_reg  out  1  writeback mux select
- wb_write_reg  out  REG_AW  writeback destination

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset: all stage valid bits, control bits, register fields and ALU select go to 0. Every output reads 0 from the first edge with reset high.
- Gating: every data-memory and register-file output is ANDed with its own stage valid bit. A bubble never writes.
- Latency: an ID bundle accepted at edge N is in EX after N, MEM after N+1 and WB after N+2.
- Destination: computed in EX as RegDest ? rd : rt, then carried to MEM and WB.
- ALU select (combinational from EX regs), mapped from ALUOp:
  - 000 -> add 0010
  - 001 -> sub 0110
  - 100 -> add 0010
  - 101 -> and 0000
  - 111 -> or 0001
  - 010 -> decode funct:
    - 100000 -> add 0010
    - 100010 -> sub 0110
    - 100100 -> and 0000
    - 100101 -> or 0001
    - 101010 -> slt 0111
    - 000000 -> sll 0011
    - 000010 -> srl 0100
    - any other funct -> 1111, and RegWrite is suppressed in EX.
  - Any other ALUOp -> 1111 with RegWrite suppressed.
- Branch:
  - taken = ex_valid & Branch & (ex_zero XOR ex_is_bne).
  - pc_src and flush equal taken, same cycle, combinationally.
  - At the next edge the ID slot enters EX as a bubble (valid 0).
- Load-use stall:
  - stall = ex_valid & ex MemRead & id_valid & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt).
  - On stall, a bubble enters EX; EX->MEM->WB continue to advance. Upstream holds the ID inputs, so the stalled instruction re-presents next cycle.
  - The stall lasts exactly one cycle per load.
- Simultaneous events:
  - Taken branch in EX with the stall condition true: the branch wins. stall is forced to 0, flush is 1, and a bubble enters EX.
  - id_valid = 0: a bubble enters EX regardless of id_ctrl.
- Reset mid-operation: all in-flight instructions are dropped with no memory or register write. The reset-cycle outputs are 0.
- Register 0: wb_reg_write is still asserted when wb_write_reg == 0. Discarding that write is the register file's job.

Decomposition:
- Package control_pkg holds:
  - ALUOp codes (ALUOP_MEM=000, ALUOP_BR=001, ALUOP_R=010, ALUOP_ADDI=100, ALUOP_ANDI=101, ALUOP_ORI=111)
  - funct constants
  - ALU select constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_BAD)
  - the id_ctrl bit indices
  - OP_BNE
- One sub-module: alu_control, a combinational ALUOp+funct -> ALU select decode with a bad-code flag. Stage registers and hazard logic stay in control_pipe.

Test Plan:
- lw then dependent add: lw $8 (rt=8, ctrl 0011011, ALUOp 000), next cycle add with rs=8 -> stall=1 for exactly one cycle; EX shows a bubble; add's ex_alu_ctrl=0010 one cycle later; lw gives mem_read=1 in its MEM cycle and wb_reg_write=1, wb_mem_to_reg=1, wb_write_reg=8 in WB.
- beq in EX with ex_zero=1 -> pc_src=1, flush=1 that cycle; the following ID instruction never asserts mem_write or wb_reg_write. Repeat with bne (opcode 000101) and ex_zero=0 -> taken. bne with ex_zero=1 -> not taken, no flush.
- R-type funct sweep (ALUOp 010) over 100000, 100010, 100100, 100101, 101010, 000000, 000010 -> ex_alu_ctrl 0010, 0110, 0000, 0001, 0111, 0011, 0100. Funct 111111 -> 1111 and no wb_reg_write.
- Taken branch in EX while ID holds an instruction hazarding on an EX load (contrived via forced ex regs) -> stall=0, flush=1.
- sw (ctrl 0000110, ALUOp 000) -> ex_alu_src=1, ex_alu_ctrl=0010, mem_write=1 in MEM, wb_reg_write=0.
- Assert reset while three valid instructions are in flight -> all outputs 0 at the next edge; no writes after reset deasserts until a new id_valid arrives.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants and inter-stage bundles for the
// control pipeline (ID/EX, EX/MEM, MEM/WB).
package control_pkg;

  localparam int REG_AW = 5;
  localparam int ALU_CW = 4;

  localparam logic [2:0] ALUOP_MEM  = 3'b000;
  localparam logic [2:0] ALUOP_BR   = 3'b001;
  localparam logic [2:0] ALUOP_R    = 3'b010;
  localparam logic [2:0] ALUOP_ADDI = 3'b100;
  localparam logic [2:0] ALUOP_ANDI = 3'b101;
  localparam logic [2:0] ALUOP_ORI  = 3'b111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef logic [ALU_CW-1:0] alu_sel_t;

  localparam alu_sel_t ALU_ADD = 4'b0010;
  localparam alu_sel_t ALU_SUB = 4'b0110;
  localparam alu_sel_t ALU_AND = 4'b0000;
  localparam alu_sel_t ALU_OR  = 4'b0001;
  localparam alu_sel_t ALU_SLT = 4'b0111;
  localparam alu_sel_t ALU_SLL = 4'b0011;
  localparam alu_sel_t ALU_SRL = 4'b0100;
  localparam alu_sel_t ALU_BAD = 4'b1111;

  localparam int CTRL_REGDST = 6;
  localparam int CTRL_BRANCH = 5;
  localparam int CTRL_MEMRD  = 4;
  localparam int CTRL_M2R    = 3;
  localparam int CTRL_MEMWR  = 2;
  localparam int CTRL_ALUSRC = 1;
  localparam int CTRL_REGWR  = 0;

  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef struct packed {
    logic              valid;
    logic [6:0]        ctrl;
    logic [2:0]        alu_op;
    logic [5:0]        funct;
    logic              is_bne;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] write_reg;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] write_reg;
  } mem_wb_t;

endpackage

// File: rtl/control_pipe_if.sv
// Decode-side bundle in, stage controls and
// hazard signals out.
interface control_pipe_if;
  import control_pkg::*;

  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [6:0]        id_ctrl;
  logic [2:0]        id_alu_op;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              ex_zero;
  logic              stall;
  logic              flush;
  logic              pc_src;
  alu_sel_t          ex_alu_ctrl;
  logic              ex_alu_src;
  logic              mem_read;
  logic              mem_write;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic [REG_AW-1:0] wb_write_reg;

  modport master (
    output id_valid, id_opcode, id_funct,
    output id_ctrl, id_alu_op,
    output id_rs, id_rt, id_rd, ex_zero,
    input  stall, flush, pc_src,
    input  ex_alu_ctrl, ex_alu_src,
    input  mem_read, mem_write,
    input  wb_reg_write, wb_mem_to_reg,
    input  wb_write_reg
  );

  modport slave (
    input  id_valid, id_opcode, id_funct,
    input  id_ctrl, id_alu_op,
    input  id_rs, id_rt, id_rd, ex_zero,
    output stall, flush, pc_src,
    output ex_alu_ctrl, ex_alu_src,
    output mem_read, mem_write,
    output wb_reg_write, wb_mem_to_reg,
    output wb_write_reg
  );

endinterface

// File: rtl/control_pipe_alu_control.sv
// ALUOp + funct to ALU select; bad flags any
// code with no defined operation.
module alu_control
  import control_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output alu_sel_t   sel,
  output logic       bad
);

  alu_sel_t r_sel;

  always_comb begin
    r_sel = ALU_BAD;
    unique case (funct)
      FN_ADD:  r_sel = ALU_ADD;
      FN_SUB:  r_sel = ALU_SUB;
      FN_AND:  r_sel = ALU_AND;
      FN_OR:   r_sel = ALU_OR;
      FN_SLT:  r_sel = ALU_SLT;
      FN_SLL:  r_sel = ALU_SLL;
      FN_SRL:  r_sel = ALU_SRL;
      default: r_sel = ALU_BAD;
    endcase
  end

  always_comb begin
    sel = ALU_BAD;
    unique case (1'b1)
      (alu_op == ALUOP_MEM):  sel = ALU_ADD;
      (alu_op == ALUOP_BR):   sel = ALU_SUB;
      (alu_op == ALUOP_R):    sel = r_sel;
      (alu_op == ALUOP_ADDI): sel = ALU_ADD;
      (alu_op == ALUOP_ANDI): sel = ALU_AND;
      (alu_op == ALUOP_ORI):  sel = ALU_OR;
      default:                sel = ALU_BAD;
    endcase
  end

  // No legal code maps to ALU_BAD.
  assign bad = (sel == ALU_BAD);

endmodule

// File: rtl/control_pipe.sv
// EX/MEM/WB control registers with branch
// resolution and load-use stall detection.
module control_pipe
  import control_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  control_pipe_if.slave ctl
);

  id_ex_t   ex_q, ex_d;
  ex_mem_t  mem_q, mem_d;
  mem_wb_t  wb_q, wb_d;
  alu_sel_t alu_sel;
  logic     alu_bad;
  logic     taken;
  logic     hazard;
  logic     load;
  logic     go;

  alu_control u_alu (
    .alu_op (ex_q.alu_op),
    .funct  (ex_q.funct),
    .sel    (alu_sel),
    .bad    (alu_bad)
  );

  always_comb begin
    taken  = ex_q.valid
           & ex_q.ctrl[CTRL_BRANCH]
           & (ctl.ex_zero ^ ex_q.is_bne);
    hazard = ex_q.valid
           & ex_q.ctrl[CTRL_MEMRD]
           & ctl.id_valid
           & (ex_q.rt != '0)
           & ((ex_q.rt == ctl.id_rs)
            | (ex_q.rt == ctl.id_rt));
    load   = ctl.id_valid & ~hazard & ~taken;
  end

  always_comb begin
    ex_d = '0;
    if (load) begin
      ex_d.valid  = 1'b1;
      ex_d.ctrl   = ctl.id_ctrl;
      ex_d.alu_op = ctl.id_alu_op;
      ex_d.funct  = ctl.id_funct;
      ex_d.is_bne = (ctl.id_opcode == OP_BNE);
      ex_d.rt     = ctl.id_rt;
      ex_d.rd     = ctl.id_rd;
    end
  end

  always_comb begin
    mem_d            = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.mem_read   = ex_q.ctrl[CTRL_MEMRD];
    mem_d.mem_write  = ex_q.ctrl[CTRL_MEMWR];
    mem_d.mem_to_reg = ex_q.ctrl[CTRL_M2R];
    mem_d.reg_write  = ex_q.ctrl[CTRL_REGWR]
                     & ~alu_bad;
    mem_d.write_reg  = ex_q.ctrl[CTRL_REGDST]
                     ? ex_q.rd : ex_q.rt;
  end

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = mem_q.valid;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.write_reg  = mem_q.write_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Outputs drop while reset is high so the
  // edge that clears state never writes.
  assign go = ~reset;

  assign ctl.stall  = go & hazard & ~taken;
  assign ctl.flush  = go & taken;
  assign ctl.pc_src = go & taken;

  assign ctl.ex_alu_ctrl =
    (go & ex_q.valid) ? alu_sel : '0;
  assign ctl.ex_alu_src =
    go & ex_q.valid & ex_q.ctrl[CTRL_ALUSRC];

  assign ctl.mem_read =
    go & mem_q.valid & mem_q.mem_read;
  assign ctl.mem_write =
    go & mem_q.valid & mem_q.mem_write;

  assign ctl.wb_reg_write =
    go & wb_q.valid & wb_q.reg_write;
  assign ctl.wb_mem_to_reg =
    go & wb_q.valid & wb_q.mem_to_reg;
  assign ctl.wb_write_reg =
    (go & wb_q.valid) ? wb_q.write_reg : '0;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench: directed hazards plus random
// traffic against an instruction-level model.
module tb_control_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_pipe_if ctl ();

  control_pipe dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl)
  );

  typedef struct {
    bit       v;
    bit [5:0] opc;
    bit [5:0] fn;
    bit [6:0] ctrl;
    bit [2:0] op;
    bit [4:0] rs;
    bit [4:0] rt;
    bit [4:0] rd;
    bit       zero;
    bit       rst;
  } stim_t;

  typedef struct {
    bit       v;
    bit       branch;
    bit       bne;
    bit       memrd;
    bit       memwr;
    bit       m2r;
    bit       alusrc;
    bit       wr;
    bit [3:0] sel;
    bit [4:0] rt;
    bit [4:0] dest;
  } instr_t;

  typedef struct {
    int       cyc;
    bit       stall;
    bit       flush;
    bit       pc_src;
    bit [3:0] alu;
    bit       src;
    bit       mrd;
    bit       mwr;
    bit       wr;
    bit       m2r;
    bit [4:0] dst;
  } exp_t;

  exp_t   expq[$];
  instr_t pipe[3];
  int     cyc = 0;
  int     passed = 0;
  int     total = 0;

  function automatic bit [3:0] ref_sel(
    bit [2:0] op, bit [5:0] fn);
    case (op)
      3'b000: return 4'b0010;
      3'b001: return 4'b0110;
      3'b100: return 4'b0010;
      3'b101: return 4'b0000;
      3'b111: return 4'b0001;
      3'b010:
        case (fn)
          6'b100000: return 4'b0010;
          6'b100010: return 4'b0110;
          6'b100100: return 4'b0000;
          6'b100101: return 4'b0001;
          6'b101010: return 4'b0111;
          6'b000000: return 4'b0011;
          6'b000010: return 4'b0100;
          default:   return 4'b1111;
        endcase
      default: return 4'b1111;
    endcase
  endfunction

  function automatic instr_t decode(stim_t s);
    instr_t r;
    r.v      = 1'b1;
    r.branch = s.ctrl[5];
    r.memrd  = s.ctrl[4];
    r.m2r    = s.ctrl[3];
    r.memwr  = s.ctrl[2];
    r.alusrc = s.ctrl[1];
    r.sel    = ref_sel(s.op, s.fn);
    r.wr     = s.ctrl[0] && (r.sel != 4'b1111);
    r.bne    = (s.opc == 6'b000101);
    r.rt     = s.rt;
    r.dest   = s.ctrl[6] ? s.rd : s.rt;
    return r;
  endfunction

  task automatic chk(string nm, int got, int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  nm, cyc, got, want);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      cyc = e.cyc;
      chk("stall", int'(ctl.stall), int'(e.stall));
      chk("flush", int'(ctl.flush), int'(e.flush));
      chk("pc_src", int'(ctl.pc_src), int'(e.pc_src));
      chk("alu_ctrl", int'(ctl.ex_alu_ctrl), int'(e.alu));
      chk("alu_src", int'(ctl.ex_alu_src), int'(e.src));
      chk("mem_read", int'(ctl.mem_read), int'(e.mrd));
      chk("mem_write", int'(ctl.mem_write), int'(e.mwr));
      chk("reg_write", int'(ctl.wb_reg_write), int'(e.wr));
      chk("mem_to_reg", int'(ctl.wb_mem_to_reg),
          int'(e.m2r));
      chk("write_reg", int'(ctl.wb_write_reg), int'(e.dst));
    end
  end

  int step_no = 0;

  task automatic step(stim_t s, output bit stalled);
    exp_t   e;
    instr_t ex, mm, wb, nb;
    bit     taken, haz;
    @(posedge clk);
    #1;
    reset         = s.rst;
    ctl.id_valid  = s.v;
    ctl.id_opcode = s.opc;
    ctl.id_funct  = s.fn;
    ctl.id_ctrl   = s.ctrl;
    ctl.id_alu_op = s.op;
    ctl.id_rs     = s.rs;
    ctl.id_rt     = s.rt;
    ctl.id_rd     = s.rd;
    ctl.ex_zero   = s.zero;
    ex = pipe[0];
    mm = pipe[1];
    wb = pipe[2];
    nb = '{default: 0};
    taken = ex.v && ex.branch && (s.zero != ex.bne);
    haz = ex.v && ex.memrd && s.v && ex.rt != 0
       && (ex.rt == s.rs || ex.rt == s.rt);
    e = '{default: 0};
    e.cyc = step_no++;
    if (!s.rst) begin
      e.stall  = haz && !taken;
      e.flush  = taken;
      e.pc_src = taken;
      e.alu    = ex.v ? ex.sel : 4'b0;
      e.src    = ex.v && ex.alusrc;
      e.mrd    = mm.v && mm.memrd;
      e.mwr    = mm.v && mm.memwr;
      e.wr     = wb.v && wb.wr;
      e.m2r    = wb.v && wb.m2r;
      e.dst    = wb.v ? wb.dest : 5'd0;
    end
    expq.push_back(e);
    stalled = e.stall;
    if (s.rst) begin
      pipe[0] = nb;
      pipe[1] = nb;
      pipe[2] = nb;
    end else begin
      pipe[2] = mm;
      pipe[1] = ex;
      pipe[0] = (s.v && !e.stall && !taken)
              ? decode(s) : nb;
    end
  endtask

  // Upstream holds the ID slot while stalled.
  task automatic send(stim_t s);
    bit st;
    for (int k = 0; k < 3; k++) begin
      step(s, st);
      if (!st) return;
    end
    total++;
    $display("FAIL hold_bound cyc=%0d got=stalled want=released",
             step_no);
  endtask

  function automatic stim_t mk(
    bit [6:0] ctrl, bit [2:0] op, bit [5:0] fn,
    bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
    stim_t s;
    s = '{default: 0};
    s.v = 1'b1;
    s.opc = 6'b000000;
    s.ctrl = ctrl;
    s.op = op;
    s.fn = fn;
    s.rs = rs;
    s.rt = rt;
    s.rd = rd;
    return s;
  endfunction

  function automatic stim_t nop(bit z);
    stim_t s;
    s = '{default: 0};
    s.zero = z;
    s.ctrl = 7'h7f;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    int k;
    k = $urandom_range(0, 9);
    s = mk(7'b0, 3'b0, 6'b0,
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)));
    s.fn = 6'($urandom);
    case (k)
      0, 1: s.ctrl = 7'b0011011;
      2: s.ctrl = 7'b0000110;
      3, 4: begin
        s.ctrl = 7'b1000001;
        s.op = 3'b010;
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 6))
            0: s.fn = 6'b100000;
            1: s.fn = 6'b100010;
            2: s.fn = 6'b100100;
            3: s.fn = 6'b100101;
            4: s.fn = 6'b101010;
            5: s.fn = 6'b000000;
            default: s.fn = 6'b000010;
          endcase
        end
      end
      5: begin
        s.ctrl = 7'b0100000;
        s.op = 3'b001;
        s.opc = $urandom_range(0, 1) != 0
              ? 6'b000101 : 6'b000100;
      end
      6: begin
        s.ctrl = 7'b0000011;
        s.op = 3'($urandom_range(0, 7));
      end
      default: begin
        s.ctrl = 7'($urandom);
        s.op = 3'($urandom);
      end
    endcase
    s.v = ($urandom_range(0, 9) != 0);
    s.zero = 1'($urandom);
    s.rst = ($urandom_range(0, 59) == 0);
    return s;
  endfunction

  localparam bit [6:0] C_LW  = 7'b0011011;
  localparam bit [6:0] C_SW  = 7'b0000110;
  localparam bit [6:0] C_R   = 7'b1000001;
  localparam bit [6:0] C_BR  = 7'b0100000;
  localparam bit [6:0] C_LBR = 7'b0110011;

  initial begin
    stim_t s;
    bit [5:0] fns[8];
    fns = '{6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010, 6'b000000,
            6'b000010, 6'b111111};
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    s = nop(1'b0);
    s.rst = 1'b1;
    send(s);
    send(s);

    send(mk(C_LW, 3'b000, 6'b0, 5'd1, 5'd8, 5'd0));
    send(mk(C_R, 3'b010, 6'b100000, 5'd8, 5'd9, 5'd10));
    repeat (4) send(nop(1'b0));

    send(mk(C_BR, 3'b001, 6'b0, 5'd1, 5'd2, 5'd0));
    s = mk(C_SW, 3'b000, 6'b0, 5'd3, 5'd4, 5'd0);
    s.zero = 1'b1;
    send(s);
    repeat (3) send(nop(1'b0));
    s = mk(C_BR, 3'b001, 6'b0, 5'd1, 5'd2, 5'd0);
    s.opc = 6'b000101;
    send(s);
    send(mk(C_R, 3'b010, 6'b100000, 5'd1, 5'd2, 5'd3));
    repeat (3) send(nop(1'b0));
    send(s);
    send(nop(1'b1));
    repeat (3) send(nop(1'b0));

    foreach (fns[i])
      send(mk(C_R, 3'b010, fns[i], 5'd1, 5'd2,
              5'(i + 5)));
    repeat (3) send(nop(1'b0));

    s = mk(C_LBR, 3'b000, 6'b0, 5'd0, 5'd8, 5'd0);
    s.opc = 6'b000100;
    send(s);
    s = mk(C_R, 3'b010, 6'b100000, 5'd8, 5'd1, 5'd2);
    s.zero = 1'b1;
    send(s);
    repeat (3) send(nop(1'b0));

    send(mk(C_SW, 3'b000, 6'b0, 5'd2, 5'd3, 5'd0));
    repeat (3) send(nop(1'b0));

    send(mk(C_LW, 3'b000, 6'b0, 5'd1, 5'd6, 5'd0));
    send(mk(C_R, 3'b010, 6'b100101, 5'd1, 5'd2, 5'd7));
    send(mk(C_SW, 3'b000, 6'b0, 5'd2, 5'd3, 5'd0));
    s = nop(1'b0);
    s.rst = 1'b1;
    send(s);
    repeat (4) send(nop(1'b0));

    repeat (400) send(rnd());
    repeat (4) send(nop(1'b0));

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
